piso_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter, the serial-side counterpart of the parallel load register.

---
 rtl/piso_serializer.sv | 156 +++++++++++++++
 tb/tb_piso_serializer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// This module accepts a WIDTH-bit word through a valid/ready handshake.
// It then presents the word one bit per cycle, advancing only on edges where shift_en=1.
// A new word may be accepted on the advancing edge of the final bit, so consecutive frames
// follow each other with no idle cycle.
// Optional feature: define PISO_PARITY_EN to append a parity bit after the data bits.
// The parity is even when PARITY_ODD=0 and odd when PARITY_ODD=1.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

  // Reject parameter values that would produce a meaningless serializer.
  if (WIDTH < 2) begin : g_bad_width
    $error("piso_serializer: WIDTH must be >= 2");
  end
  if (!(LSB_FIRST == 0 || LSB_FIRST == 1)) begin : g_bad_order
    $error("piso_serializer: LSB_FIRST must be 0 or 1");
  end
  if (!(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_bad_parity
    $error("piso_serializer: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`ifdef PISO_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  // The bit currently on the wire is always at the outgoing end of the shift register.
  logic             head_bit;
  logic [WIDTH-1:0] shifted;
  assign head_bit = (LSB_FIRST != 0) ? shift_reg[0] : shift_reg[WIDTH-1];
  assign shifted  = (LSB_FIRST != 0) ? (shift_reg >> 1) : (shift_reg << 1);

  // State and datapath registers; an asynchronous reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
`ifdef PISO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      cnt_reg    <= cnt_next;
`ifdef PISO_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
`ifdef PISO_PARITY_EN
    parity_next  = parity_reg;
`endif
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    done         = 1'b0;
    load_ready   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // shift_en has no meaning while idle; only a new word matters here.
        load_ready = 1'b1;
      end

      ST_SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = head_bit;
`ifndef PISO_PARITY_EN
        // Without parity the last data bit closes the frame, so it carries done and the overlap.
        done       = (cnt_reg == LAST_DATA);
        load_ready = done & shift_en;
`endif
        if (shift_en) begin
          if (cnt_reg == LAST_DATA) begin
`ifdef PISO_PARITY_EN
            state_next = ST_PARITY;
            cnt_next   = cnt_reg + CNT_W'(1);
`else
            state_next = ST_IDLE;
            shift_next = '0;
            cnt_next   = '0;
`endif
          end else begin
            shift_next = shifted;
            cnt_next   = cnt_reg + CNT_W'(1);
          end
        end
      end

`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        serial_valid = 1'b1;
        serial_out   = parity_reg;
        done         = 1'b1;
        load_ready   = shift_en;
        if (shift_en) begin
          state_next = ST_IDLE;
          shift_next = '0;
          cnt_next   = '0;
        end
      end
`endif

      default: begin
        state_next = ST_IDLE;
        shift_next = '0;
        cnt_next   = '0;
      end
    endcase

    // An accept overrides whatever the frame logic chose.
    // This lets the next word start right behind the final bit.
    if (load_valid && load_ready) begin
      state_next  = ST_SHIFT;
      shift_next  = parallel_in;
      cnt_next    = '0;
`ifdef PISO_PARITY_EN
      parity_next = (^parallel_in) ^ (PARITY_ODD != 0);
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer.
// Two instances share the same stimulus: one sends MSB first, the other sends LSB first.
// On every accept, the stimulus side pushes one expected entry per frame bit.
// A negedge monitor compares the wire against the head of the queue.
// The head entry is popped on advancing cycles and held during stalls.
module tb_piso_serializer;

  localparam int W       = 8;
  localparam int PAR_ODD = 0;
`ifdef PISO_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] parallel_in = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic m_ready, m_out, m_valid, m_done;
  logic l_ready, l_out, l_valid, l_done;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(0), .PARITY_ODD(PAR_ODD)) u_msb (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(m_ready), .shift_en(shift_en), .serial_out(m_out),
    .serial_valid(m_valid), .done(m_done)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1), .PARITY_ODD(PAR_ODD)) u_lsb (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(l_ready), .shift_en(shift_en), .serial_out(l_out),
    .serial_valid(l_valid), .done(l_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mb;
    logic lb;
    logic dn;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   bits_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      if (k < W) begin
        e.mb = d[W-1-k];
        e.lb = d[k];
      end else begin
        e.mb = (^d) ^ (PAR_ODD != 0);
        e.lb = (^d) ^ (PAR_ODD != 0);
      end
      e.dn = (k == N - 1);
      q.push_back(e);
    end
  endtask

  // Called at posedge+1. Drives one cycle, checks load_ready and updates the model.
  task automatic step(input logic lv, input logic [W-1:0] d, input logic se);
    logic exp_ready;
    logic acc;
    load_valid  = lv;
    parallel_in = d;
    shift_en    = se;
    #1;
    exp_ready = (bits_left == 0) || (bits_left == 1 && se);
    chk("load_ready_msb", m_ready, exp_ready);
    chk("load_ready_lsb", l_ready, exp_ready);
    acc = lv && exp_ready;
    @(posedge clk);
    if (bits_left > 0 && se) bits_left--;
    if (acc) begin
      bits_left = N;
      push_frame(d);
      $display("accept word %02h (frame %0d bits)", d, N);
    end
    #1;
  endtask

  task automatic drain();
    repeat (N + 2) step(1'b0, '0, 1'b1);
  endtask

  // Monitor: compare the serial side against the scoreboard away from the active edge.
  always @(negedge clk) begin
    chk("serial_valid_msb", m_valid, bits_left > 0);
    chk("serial_valid_lsb", l_valid, bits_left > 0);
    if (m_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=valid required=idle at %0t", $time);
      end else begin
        chk("serial_out_msb", m_out, q[0].mb);
        chk("serial_out_lsb", l_out, q[0].lb);
        chk("done_msb", m_done, q[0].dn);
        chk("done_lsb", l_done, q[0].dn);
        if (shift_en) void'(q.pop_front());
      end
    end else begin
      chk("idle_out_msb", m_out, 0);
      chk("idle_out_lsb", l_out, 0);
      chk("idle_done_msb", m_done, 0);
      chk("idle_done_lsb", l_done, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while reset is held.
    #12;
    chk("rst_valid", m_valid, 0);
    chk("rst_out", m_out, 0);
    chk("rst_done", m_done, 0);
    chk("rst_ready", m_ready, 1);
    chk("rst_ready_lsb", l_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // A5 streamed with no stalls.
    step(1'b1, 8'hA5, 1'b1);
    drain();

    // 01: a single set bit that lands first on the LSB-first instance.
    step(1'b1, 8'h01, 1'b1);
    drain();

    // FF then 00 back to back with load_valid held high.
    step(1'b1, 8'hFF, 1'b1);
    repeat (N) step(1'b1, 8'h00, 1'b1);
    drain();

    // A5 with a three-cycle stall while bit 2 is on the wire.
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    drain();

    // Accept with shift_en low, then stall on the final bit.
    // done must be held and load_ready must stay low throughout the stall.
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, '0, 1'b0);
    repeat (N - 1) step(1'b0, '0, 1'b1);
    repeat (2) step(1'b1, 8'hC3, 1'b0);
    drain();

    // Asynchronous reset while bit 4 is on the wire, then a clean 3C frame.
    step(1'b1, 8'hA5, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_out", m_out, 0);
    chk("async_rst_done", m_done, 0);
    chk("async_rst_ready", m_ready, 1);
    chk("async_rst_valid_lsb", l_valid, 0);
    q.delete();
    bits_left = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 8'h3C, 1'b1);
    drain();

    // 0A: with parity enabled, this frame carries an even-parity bit of 0.
    step(1'b1, 8'h0A, 1'b1);
    drain();

    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
